i2c_slave_regif: RTL and testbench

// I2C target (slave) that bridges bus transactions onto a simple byte-wide register

---
 rtl/i2c_slave_regif_if.sv | 29 ++
 rtl/i2c_slave_regif.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regif_if.sv
// Byte-wide register access bus between the I2C target bridge and a register file.
//   reg_addr     register address for the access (current pointer)
//   reg_wr_data  write data, valid with reg_wr_en
//   reg_wr_en    one-cycle write strobe
//   reg_rd_req   one-cycle read request
//   reg_rd_data  read data, valid with reg_rd_valid
//   reg_rd_valid read data valid, one or more cycles after reg_rd_req
// master: the bridge (issues accesses); slave: the register file.
`timescale 1ns/1ps
interface i2c_slave_regif_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [7:0]            reg_wr_data;
   logic                  reg_wr_en;
   logic                  reg_rd_req;
   logic [7:0]            reg_rd_data;
   logic                  reg_rd_valid;

   modport master (
      output reg_addr, reg_wr_data, reg_wr_en, reg_rd_req,
      input  reg_rd_data, reg_rd_valid
   );

   modport slave (
      input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_req,
      output reg_rd_data, reg_rd_valid
   );
endinterface

// File: rtl/i2c_slave_regif.sv
// I2C target bridging bus transactions onto a byte-wide register interface.
// Write: first data byte loads the register pointer, further bytes are written
// at the pointer. Read: each byte is fetched at the pointer while SCL is held
// low until the register file answers. The pointer auto-increments and wraps.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   rif                register bus (master side)
//   busy               START seen and no STOP yet (any target)
//   addressed          this device selected, until STOP / repeated START
//   i2c_scl_i/o/t      SCL open-drain pin (t=1 releases, o fixed 0)
//   i2c_sda_i/o/t      SDA open-drain pin (t=1 releases, o fixed 0)
`timescale 1ns/1ps
module i2c_slave_regif #(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         ADDR_WIDTH = 8,
   parameter int         FILTER_LEN = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   i2c_slave_regif_if.master   rif,
   output logic                busy,
   output logic                addressed,
   input  logic                i2c_scl_i,
   output logic                i2c_scl_o,
   output logic                i2c_scl_t,
   input  logic                i2c_sda_i,
   output logic                i2c_sda_o,
   output logic                i2c_sda_t
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR, S_WDATA, S_ACK_WDATA,
      S_RFETCH, S_RDATA, S_RACK, S_IGNORE
   } state_t;

   // Reset asserts immediately, releases on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_i_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_i_n = rst_sync[1];

   // Input conditioning, bit 0 = SCL, bit 1 = SDA. The filtered value only
   // follows the synchronized pin after FILTER_LEN consecutive differing samples.
   logic [1:0]         sync1, sync2, filt, filt_q;
   logic [1:0][CW-1:0] fcnt;

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         filt   <= 2'b11;
         filt_q <= 2'b11;
         fcnt   <= '0;
      end else begin
         sync1  <= {i2c_sda_i, i2c_scl_i};
         sync2  <= sync1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CW'(FILTER_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + CW'(1);
            end
         end
      end
   end

   logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
   assign scl_f     = filt[0];
   assign sda_f     = filt[1];
   assign scl_rise  =  filt[0] & ~filt_q[0];
   assign scl_fall  = ~filt[0] &  filt_q[0];
   assign start_det =  filt[0] &  filt_q[0] &  filt_q[1] & ~filt[1];
   assign stop_det  =  filt[0] &  filt_q[0] & ~filt_q[1] &  filt[1];

   state_t                state, state_n;
   logic [3:0]            bit_cnt, bit_cnt_n;
   logic [7:0]            shreg, shreg_n, rx_byte;
   logic [ADDR_WIDTH-1:0] ptr, ptr_n, addr_q, addr_n;
   logic [7:0]            wdata_q, wdata_n;
   // ACK states: ACK bit being driven; RFETCH: data latched; RACK: master ACKed
   logic                  phase, phase_n;
   logic                  sda_t_q, sda_t_n, scl_t_q, scl_t_n;
   logic                  wr_en_q, wr_en_n, rd_req_q, rd_req_n;
   logic                  busy_q, busy_n, addressed_q, addressed_n;

   assign rx_byte = {shreg[6:0], sda_f};

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         state       <= S_IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         ptr         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         phase       <= 1'b0;
         sda_t_q     <= 1'b1;
         scl_t_q     <= 1'b1;
         wr_en_q     <= 1'b0;
         rd_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         addressed_q <= 1'b0;
      end else begin
         state       <= state_n;
         bit_cnt     <= bit_cnt_n;
         shreg       <= shreg_n;
         ptr         <= ptr_n;
         addr_q      <= addr_n;
         wdata_q     <= wdata_n;
         phase       <= phase_n;
         sda_t_q     <= sda_t_n;
         scl_t_q     <= scl_t_n;
         wr_en_q     <= wr_en_n;
         rd_req_q    <= rd_req_n;
         busy_q      <= busy_n;
         addressed_q <= addressed_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shreg_n     = shreg;
      ptr_n       = ptr;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      phase_n     = phase;
      sda_t_n     = sda_t_q;
      scl_t_n     = scl_t_q;
      wr_en_n     = 1'b0;
      rd_req_n    = 1'b0;
      busy_n      = busy_q;
      addressed_n = addressed_q;

      if (start_det || stop_det) begin
         state_n     = start_det ? S_ADDR : S_IDLE;
         busy_n      = start_det;
         addressed_n = 1'b0;
         sda_t_n     = 1'b1;
         scl_t_n     = 1'b1;
         bit_cnt_n   = '0;
         phase_n     = 1'b0;
      end else begin
         case (state)
            S_ADDR, S_PTR, S_WDATA: begin
               if (scl_rise) begin
                  shreg_n   = rx_byte;
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_n = '0;
                     phase_n   = 1'b0;
                     if (state == S_ADDR) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                           state_n     = S_ACK_ADDR;
                           addressed_n = 1'b1;
                        end else begin
                           state_n = S_IGNORE;
                        end
                     end else if (state == S_PTR) begin
                        ptr_n   = ADDR_WIDTH'(rx_byte);
                        state_n = S_ACK_PTR;
                     end else begin
                        wr_en_n = 1'b1;
                        addr_n  = ptr;
                        wdata_n = rx_byte;
                        ptr_n   = ptr + ADDR_WIDTH'(1);
                        state_n = S_ACK_WDATA;
                     end
                  end
               end
            end
            S_ACK_ADDR, S_ACK_PTR, S_ACK_WDATA: begin
               if (scl_fall) begin
                  if (!phase) begin
                     sda_t_n = 1'b0;
                     phase_n = 1'b1;
                  end else begin
                     sda_t_n = 1'b1;
                     phase_n = 1'b0;
                     // shreg[0] still holds the R/W bit of the address byte
                     if (state == S_ACK_ADDR && shreg[0]) begin
                        state_n  = S_RFETCH;
                        scl_t_n  = 1'b0;
                        rd_req_n = 1'b1;
                        addr_n   = ptr;
                     end else if (state == S_ACK_ADDR) begin
                        state_n = S_PTR;
                     end else begin
                        state_n = S_WDATA;
                     end
                  end
               end
            end
            S_RFETCH: begin
               if (phase) begin
                  // MSB has been on SDA for a cycle; let the master clock it
                  scl_t_n = 1'b1;
                  phase_n = 1'b0;
                  state_n = S_RDATA;
               end else if (rif.reg_rd_valid && !rd_req_q) begin
                  shreg_n   = rif.reg_rd_data;
                  sda_t_n   = rif.reg_rd_data[7];
                  ptr_n     = ptr + ADDR_WIDTH'(1);
                  bit_cnt_n = 4'd1;
                  phase_n   = 1'b1;
               end
            end
            S_RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_t_n   = 1'b1;
                     bit_cnt_n = '0;
                     phase_n   = 1'b0;
                     state_n   = S_RACK;
                  end else begin
                     sda_t_n   = shreg[6];
                     shreg_n   = {shreg[6:0], 1'b0};
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end
            S_RACK: begin
               if (scl_rise) begin
                  if (sda_f) state_n = S_IGNORE;
                  else       phase_n = 1'b1;
               end else if (scl_fall && phase) begin
                  state_n  = S_RFETCH;
                  phase_n  = 1'b0;
                  scl_t_n  = 1'b0;
                  rd_req_n = 1'b1;
                  addr_n   = ptr;
               end
            end
            default: ;
         endcase
      end
   end

   assign rif.reg_addr    = addr_q;
   assign rif.reg_wr_data = wdata_q;
   assign rif.reg_wr_en   = wr_en_q;
   assign rif.reg_rd_req  = rd_req_q;
   assign busy            = busy_q;
   assign addressed       = addressed_q;
   assign i2c_scl_t       = scl_t_q;
   assign i2c_sda_t       = sda_t_q;
   assign i2c_scl_o       = 1'b0;
   assign i2c_sda_o       = 1'b0;

endmodule

// File: tb/tb_i2c_slave_regif.sv
`timescale 1ns/1ps
module tb_i2c_slave_regif;

   localparam int Q   = 25;     // quarter SCL period in clk cycles
   localparam int TMO = 5000;

   logic clk = 1'b0;
   logic rst_n;
   logic scl_m, sda_m;
   logic busy, addressed;
   logic i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
   wire  scl_line = scl_m & (i2c_scl_t | i2c_scl_o);
   wire  sda_line = sda_m & (i2c_sda_t | i2c_sda_o);

   always #5 clk = ~clk;

   i2c_slave_regif_if #(.ADDR_WIDTH(8)) rif ();

   i2c_slave_regif #(.DEV_ADDR(7'h50), .ADDR_WIDTH(8), .FILTER_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rif       (rif),
      .busy      (busy),
      .addressed (addressed),
      .i2c_scl_i (scl_line),
      .i2c_scl_o (i2c_scl_o),
      .i2c_scl_t (i2c_scl_t),
      .i2c_sda_i (sda_line),
      .i2c_sda_o (i2c_sda_o),
      .i2c_sda_t (i2c_sda_t)
   );

   int n_cmp, n_bad;

   // register file model and activity logs
   logic [7:0] mem [0:255];
   logic       model_en;
   int         dly = 0;
   logic [7:0] pend_addr;
   int         wr_cnt = 0, rd_cnt = 0, stretch_cnt = 0, sda_drv_cnt = 0;
   logic [7:0] wr_addr_log [0:63];
   logic [7:0] wr_data_log [0:63];
   logic [7:0] rd_addr_log [0:63];

   always @(posedge clk) begin
      rif.reg_rd_valid <= 1'b0;
      if (rif.reg_rd_req) begin
         rd_addr_log[rd_cnt[5:0]] = rif.reg_addr;
         rd_cnt++;
         if (model_en) begin
            dly       = 5;
            pend_addr = rif.reg_addr;
         end
      end else if (dly != 0) begin
         dly--;
         if (dly == 0) begin
            rif.reg_rd_valid <= 1'b1;
            rif.reg_rd_data  <= mem[pend_addr];
         end
      end
      if (rif.reg_wr_en) begin
         wr_addr_log[wr_cnt[5:0]] = rif.reg_addr;
         wr_data_log[wr_cnt[5:0]] = rif.reg_wr_data;
         wr_cnt++;
      end
      if (!i2c_scl_t) stretch_cnt++;
      if (!i2c_sda_t) sda_drv_cnt++;
   end

   // ---------------- bus master ----------------
   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic wait_scl_high();
      int n = 0;
      while (scl_line !== 1'b1 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (scl_line !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL scl_release: scl=%b, want 1 within %0d cycles", scl_line, TMO);
      end
   endtask

   task automatic i2c_start();
      sda_m = 1'b0; qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; wait_scl_high(); qwait();
      sda_m = 1'b0; qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; qwait();
      scl_m = 1'b1; wait_scl_high(); qwait();
      sda_m = 1'b1; qwait();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; qwait();
      scl_m = 1'b1; wait_scl_high(); qwait();
      scl_m = 1'b0; qwait();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; wait_scl_high();
      repeat (Q/2) @(negedge clk);
      b = sda_line;
      repeat (Q - Q/2) @(negedge clk);
      scl_m = 1'b0; qwait();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         read_bit(s);
         d[i] = s;
      end
      write_bit(~ack);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({i2c_scl_t, i2c_sda_t} !== 2'b11) begin n_bad++; $display("FAIL rst_t: got %b want 11", {i2c_scl_t, i2c_sda_t}); end
      n_cmp++; if ({i2c_scl_o, i2c_sda_o} !== 2'b00) begin n_bad++; $display("FAIL rst_o: got %b want 00", {i2c_scl_o, i2c_sda_o}); end
      n_cmp++; if ({rif.reg_wr_en, rif.reg_rd_req, busy, addressed} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {rif.reg_wr_en, rif.reg_rd_req, busy, addressed}); end
      n_cmp++; if ({rif.reg_addr, rif.reg_wr_data} !== 16'h0000) begin n_bad++; $display("FAIL rst_regs: got %h want 0000", {rif.reg_addr, rif.reg_wr_data}); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3;
      int w0 = wr_cnt;
      i2c_start();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_start: got %b want 1", busy); end
      write_byte(8'hA0, a0);
      n_cmp++; if (addressed !== 1'b1) begin n_bad++; $display("FAIL wr_addressed: got %b want 1", addressed); end
      write_byte(8'h10, a1);
      write_byte(8'hAA, a2);
      write_byte(8'hBB, a3);
      i2c_stop();
      n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_bad++; $display("FAIL wr_acks: got %b want 1111", {a0, a1, a2, a3}); end
      n_cmp++; if ({busy, addressed} !== 2'b00) begin n_bad++; $display("FAIL wr_after_stop: got %b want 00", {busy, addressed}); end
      n_cmp++; if (wr_cnt - w0 !== 2) begin n_bad++; $display("FAIL wr_count: got %0d want 2", wr_cnt - w0); end
      n_cmp++; if ({wr_addr_log[w0], wr_data_log[w0]} !== 16'h10AA) begin n_bad++; $display("FAIL wr_first: got %h want 10aa", {wr_addr_log[w0], wr_data_log[w0]}); end
      n_cmp++; if ({wr_addr_log[w0+1], wr_data_log[w0+1]} !== 16'h11BB) begin n_bad++; $display("FAIL wr_second: got %h want 11bb", {wr_addr_log[w0+1], wr_data_log[w0+1]}); end
   endtask

   task automatic test_read();
      logic a0, a1, a2;
      logic [7:0] d0, d1;
      int r0 = rd_cnt;
      int s0, s1, s2;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h20, a1);
      i2c_rstart();
      s0 = stretch_cnt;
      write_byte(8'hA1, a2);
      s1 = stretch_cnt;
      read_byte(1'b1, d0);
      s2 = stretch_cnt;
      read_byte(1'b0, d1);
      i2c_stop();
      n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL rd_acks: got %b want 111", {a0, a1, a2}); end
      n_cmp++; if (d0 !== 8'h5A) begin n_bad++; $display("FAIL rd_byte0: got %h want 5a", d0); end
      n_cmp++; if (d1 !== 8'hC3) begin n_bad++; $display("FAIL rd_byte1: got %h want c3", d1); end
      n_cmp++; if (rd_cnt - r0 !== 2) begin n_bad++; $display("FAIL rd_count: got %0d want 2", rd_cnt - r0); end
      n_cmp++; if ({rd_addr_log[r0], rd_addr_log[r0+1]} !== 16'h2021) begin n_bad++; $display("FAIL rd_addrs: got %h want 2021", {rd_addr_log[r0], rd_addr_log[r0+1]}); end
      // req cycle + 5-cycle model delay + latch + one cycle of MSB setup
      n_cmp++; if (s1 - s0 !== 8) begin n_bad++; $display("FAIL rd_stretch0: got %0d want 8 cycles", s1 - s0); end
      n_cmp++; if (s2 - s1 !== 8) begin n_bad++; $display("FAIL rd_stretch1: got %0d want 8 cycles", s2 - s1); end
      n_cmp++; if (stretch_cnt - s2 !== 0) begin n_bad++; $display("FAIL rd_no_fetch_after_nack: got %0d want 0 cycles", stretch_cnt - s2); end
   endtask

   task automatic test_other_addr();
      logic a0, a1;
      int w0 = wr_cnt, r0 = rd_cnt, d0 = sda_drv_cnt;
      i2c_start();
      write_byte(8'hA2, a0);
      write_byte(8'h55, a1);
      n_cmp++; if ({busy, addressed} !== 2'b10) begin n_bad++; $display("FAIL oa_flags: got %b want 10", {busy, addressed}); end
      i2c_stop();
      n_cmp++; if ({a0, a1} !== 2'b00) begin n_bad++; $display("FAIL oa_acks: got %b want 00", {a0, a1}); end
      n_cmp++; if (sda_drv_cnt - d0 !== 0) begin n_bad++; $display("FAIL oa_sda_driven: got %0d want 0 cycles", sda_drv_cnt - d0); end
      n_cmp++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin n_bad++; $display("FAIL oa_strobes: got %0d want 0", (wr_cnt - w0) + (rd_cnt - r0)); end
   endtask

   task automatic test_wrap();
      logic a;
      int w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'hFF, a);
      write_byte(8'h01, a);
      write_byte(8'h02, a);
      i2c_stop();
      n_cmp++; if (wr_cnt - w0 !== 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", wr_cnt - w0); end
      n_cmp++; if ({wr_addr_log[w0], wr_data_log[w0]} !== 16'hFF01) begin n_bad++; $display("FAIL wrap_first: got %h want ff01", {wr_addr_log[w0], wr_data_log[w0]}); end
      n_cmp++; if ({wr_addr_log[w0+1], wr_data_log[w0+1]} !== 16'h0002) begin n_bad++; $display("FAIL wrap_second: got %h want 0002", {wr_addr_log[w0+1], wr_data_log[w0+1]}); end
   endtask

   task automatic test_stop_mid();
      logic a;
      int w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h33, a);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      i2c_stop();
      n_cmp++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL stopmid_no_write: got %0d want 0", wr_cnt - w0); end
      n_cmp++; if ({busy, addressed} !== 2'b00) begin n_bad++; $display("FAIL stopmid_flags: got %b want 00", {busy, addressed}); end
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h40, a);
      write_byte(8'h77, a);
      i2c_stop();
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL stopmid_next_ack: got %b want 1", a); end
      n_cmp++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL stopmid_next_count: got %0d want 1", wr_cnt - w0); end
      n_cmp++; if ({wr_addr_log[w0], wr_data_log[w0]} !== 16'h4077) begin n_bad++; $display("FAIL stopmid_next_write: got %h want 4077", {wr_addr_log[w0], wr_data_log[w0]}); end
   endtask

   task automatic test_reset_stretch();
      logic a;
      int w0;
      model_en = 1'b0;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h30, a);
      i2c_rstart();
      write_byte(8'hA1, a);
      n_cmp++; if (i2c_scl_t !== 1'b0) begin n_bad++; $display("FAIL rs_stretching: got scl_t=%b want 0", i2c_scl_t); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({i2c_scl_t, i2c_sda_t} !== 2'b11) begin n_bad++; $display("FAIL rs_release: got %b want 11", {i2c_scl_t, i2c_sda_t}); end
      n_cmp++; if ({rif.reg_wr_en, rif.reg_rd_req, busy, addressed} !== 4'b0000) begin n_bad++; $display("FAIL rs_flags: got %b want 0000", {rif.reg_wr_en, rif.reg_rd_req, busy, addressed}); end
      n_cmp++; if ({rif.reg_addr, rif.reg_wr_data} !== 16'h0000) begin n_bad++; $display("FAIL rs_regs: got %h want 0000", {rif.reg_addr, rif.reg_wr_data}); end
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      model_en = 1'b1;
      w0 = wr_cnt;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h05, a);
      write_byte(8'h66, a);
      i2c_stop();
      n_cmp++; if ({wr_addr_log[w0], wr_data_log[w0], 8'(wr_cnt - w0)} !== 24'h056601) begin n_bad++; $display("FAIL rs_recover: got %h want 056601", {wr_addr_log[w0], wr_data_log[w0], 8'(wr_cnt - w0)}); end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      scl_m    = 1'b1;
      sda_m    = 1'b1;
      rst_n    = 1'b0;
      model_en = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
      mem[8'h20] = 8'h5A;
      mem[8'h21] = 8'hC3;
      test_reset();
      test_write();
      test_read();
      test_other_addr();
      test_wrap();
      test_stop_mid();
      test_reset_stretch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
